lcd_writer: RTL



---
 rtl/lcd_pkg.sv | 38 +++
 rtl/lcd_delay_timer.sv | 28 ++
 rtl/lcd_writer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 init commands and wait constants for lcd_writer
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC_WAIT
    } lcd_state_t;

    localparam logic [7:0] LCD_FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] LCD_DISP_ON       = 8'h0C;
    localparam logic [7:0] LCD_CLEAR         = 8'h01;
    localparam logic [7:0] LCD_ENTRY_INC     = 8'h06;

    localparam int INIT_LEN      = 7;
    localparam int PWR_WAIT_US   = 15000;
    localparam int INIT_WAIT0_US = 4100;
    localparam int INIT_WAIT1_US = 100;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd4:    return LCD_DISP_ON;
            3'd5:    return LCD_CLEAR;
            3'd6:    return LCD_ENTRY_INC;
            default: return LCD_FUNC_SET_8B2L;
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - loadable down-counter; done flags the cycle whose edge brings the count to 0
module lcd_delay_timer #(
    parameter int            CW          = 16,
    parameter logic [CW-1:0] RESET_COUNT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_COUNT;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    // A load of N therefore gives exactly N cycles before the owner state moves on.
    assign done = (count == CW'(1));

endmodule

// File: rtl/lcd_writer.sv
// rtl/lcd_writer.sv - HD44780 8-bit write controller; LCD_WRITER_INIT_EN enables the built-in power-up init
module lcd_writer
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int E_CYCLES      = 25,
    parameter int EXEC_SHORT_US = 40,
    parameter int EXEC_LONG_US  = 1640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam int US = CLK_FREQ_HZ / 1_000_000;
    localparam int CW = $clog2(PWR_WAIT_US * US + 1);

    localparam logic [CW-1:0] E_CNT     = CW'(E_CYCLES);
    localparam logic [CW-1:0] SHORT_CNT = CW'(EXEC_SHORT_US * US);
    localparam logic [CW-1:0] LONG_CNT  = CW'(EXEC_LONG_US * US);

`ifdef LCD_WRITER_INIT_EN
    localparam logic [CW-1:0] PWR_CNT   = CW'(PWR_WAIT_US * US);
    localparam logic [CW-1:0] W0_CNT    = CW'(INIT_WAIT0_US * US);
    localparam logic [CW-1:0] W1_CNT    = CW'(INIT_WAIT1_US * US);
    localparam lcd_state_t    RST_STATE = PWR_WAIT;
    localparam logic [CW-1:0] RST_COUNT = PWR_CNT;
`else
    localparam lcd_state_t    RST_STATE = IDLE;
    localparam logic [CW-1:0] RST_COUNT = '0;
`endif

    lcd_state_t    state;
    logic [CW-1:0] exec_cnt;
    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          tmr_done;

    assign lcd_rw = 1'b0;

    // The timer is armed on the edge that enters PULSE or EXEC_WAIT.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = E_CNT;
        if (state == SETUP) begin
            tmr_load  = 1'b1;
            tmr_value = E_CNT;
        end else if (state == HOLD) begin
            tmr_load  = 1'b1;
            tmr_value = exec_cnt;
        end
    end

    lcd_delay_timer #(
        .CW          (CW),
        .RESET_COUNT (RST_COUNT)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

`ifdef LCD_WRITER_INIT_EN
    logic [2:0]    init_idx;
    logic [CW-1:0] init_wait;

    always_comb begin
        case (init_idx)
            3'd0:    init_wait = W0_CNT;
            3'd1:    init_wait = W1_CNT;
            3'd5:    init_wait = LONG_CNT;
            default: init_wait = SHORT_CNT;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            in_ready  <= 1'b0;
            init_done <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            exec_cnt  <= SHORT_CNT;
`ifdef LCD_WRITER_INIT_EN
            init_idx  <= 3'd0;
`endif
        end else begin
            case (state)
`ifdef LCD_WRITER_INIT_EN
                PWR_WAIT: begin
                    if (tmr_done) state <= INIT_LOAD;
                end
                INIT_LOAD: begin
                    lcd_rs   <= 1'b0;
                    lcd_data <= init_byte(init_idx);
                    exec_cnt <= init_wait;
                    state    <= SETUP;
                end
`endif
                IDLE: begin
                    if (!init_done) begin
                        init_done <= 1'b1;
                        in_ready  <= 1'b1;
                    end else if (in_valid && in_ready) begin
                        lcd_rs   <= in_rs;
                        lcd_data <= in_data;
                        exec_cnt <= is_long_cmd(in_rs, in_data) ? LONG_CNT : SHORT_CNT;
                        in_ready <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    lcd_e <= 1'b1;
                    state <= PULSE;
                end
                PULSE: begin
                    if (tmr_done) begin
                        lcd_e <= 1'b0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    state <= EXEC_WAIT;
                end
                EXEC_WAIT: begin
                    if (tmr_done) begin
`ifdef LCD_WRITER_INIT_EN
                        if (!init_done && init_idx != 3'(INIT_LEN - 1)) begin
                            init_idx <= init_idx + 3'd1;
                            state    <= INIT_LOAD;
                        end else begin
                            init_done <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
`else
                        in_ready <= 1'b1;
                        state    <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
